serial_ripple_borrow_subtractor: RTL and testbench
==================================================

# serial_ripple_borrow_subtractor

Multi-cycle, chunked ripple-borrow subtractor computing `diff = a - b - bin` with borrow-out and optional signed overflow. It processes CHUNK bits per clock using propagate/generate borrow logic. It sits in the arithmetic library as the subtract-direction companion to the combinational ripple-carry adder, for datapaths that trade latency for area. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, 64, operand and result width; must be a multiple of CHUNK.
- `CHUNK`, 8, bits resolved per RUN cycle; 1 ≤ CHUNK ≤ WIDTH.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  operand set presented.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `bin`  input  1  borrow-in.
- `out_valid`  output  1  result held on outputs.
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  WIDTH  `a - b - bin` mod 2^WIDTH.
- `bout`  output  1  unsigned borrow-out: 1 iff `a < b + bin`.
- `ovf`  output  1  two's-complement overflow; see Configuration.

## Operation
- FSM has three states: IDLE, RUN and DONE.
  - **IDLE:** `in_ready`=1, `out_valid`=0. When `in_valid & in_ready`, latch `a`, `b` and `bin` into operand registers. Set the chunk index to 0, load the running borrow with `bin`, and go to RUN.
  - **RUN:** each cycle resolves chunk `idx`, bits `[idx*CHUNK +: CHUNK]`.
    - Per bit: `p = ~(a^b)` and `g = ~a & b`.
    - Borrow chain: `br[i+1] = g[i] | (p[i] & br[i])`.
    - Difference bit: `d[i] = a[i]^b[i]^br[i]`.
    - Write the chunk's difference bits into the result register and store the chunk's borrow-out as the running borrow.
    - After the chunk with `idx = WIDTH/CHUNK-1`, go to DONE.
  - **DONE:** `out_valid`=1. `diff`, `bout` and `ovf` are stable. On `out_ready`, return to IDLE.
- `in_ready` is 0 throughout RUN and DONE. Inputs are ignored there, so operand changes after acceptance have no effect.
- Accepting a new input in the same cycle as the output handshake is not allowed. The first accept is possible one cycle after return to IDLE.
- `bout` is the final running borrow. `diff` is registered, not combinational from the inputs.
- `WIDTH == CHUNK` degenerates to one RUN cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0, FSM in IDLE, index 0.
- Latency: with accept at edge k, `out_valid` rises after edge k+N+… is not used; it rises exactly after edge k+N, where N=WIDTH/CHUNK.
- Throughput: at most one operation per N+2 cycles with `out_ready` tied high.
- Backpressure: while `out_valid & ~out_ready`, all outputs hold indefinitely.
- Reset mid-operation: asserting `rst_n` low in RUN or DONE immediately clears everything to the reset values. The in-flight result is discarded and nothing is emitted after release.
- The index counter stops at N-1 and never wraps.

## Configuration
- `SUB_OVERFLOW_EN` defined: extra register stage logic captures the borrow into the MSB. At DONE, `ovf = br_into_msb ^ bout`, equivalently `(a[W-1]^b[W-1]) & (diff[W-1]^a[W-1])` with bin folded in. The flag is valid with `out_valid` and holds under backpressure.
- `SUB_OVERFLOW_EN` undefined: the `ovf` port exists but is tied to 0 and the MSB-borrow capture logic is removed.

## Test plan
Bench parameters are WIDTH=8, CHUNK=4 (N=2), plus one pass at the defaults.
1. **Basic subtract.** Drive `a`=0x10, `b`=0x01, `bin`=0. Require `out_valid` 2 cycles after accept, `diff`=0x0F, `bout`=0, `ovf`=0.
2. **Unsigned underflow.** Drive `a`=0x00, `b`=0x01, `bin`=0. Require `diff`=0xFF, `bout`=1.
3. **Borrow-in across chunks.** Drive `a`=0x05, `b`=0x05, `bin`=1. Require `diff`=0xFF, `bout`=1. Also drive `a`=0x10, `b`=0x00, `bin`=1: the borrow ripples from the low chunk to the high chunk, so require `diff`=0x0F, `bout`=0.
4. **Signed overflow.** Drive `a`=0x80, `b`=0x01.
   - With `SUB_OVERFLOW_EN` defined: require `diff`=0x7F, `ovf`=1, `bout`=0.
   - Without it: require `ovf`=0.
5. **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE. Require `diff`/`bout` stable, `in_ready`=0, and `in_valid` pulses ignored. After `out_ready`=1, require IDLE one cycle later.
6. **Reset mid-RUN.** Assert `rst_n`=0 on the cycle after accept. Require outputs at reset values immediately, with no `out_valid` after release. A following operation, 0x33−0x11, must return 0x22.

Source files
------------

// File: rtl/serial_ripple_borrow_subtractor_if.sv
// Operand/result handshake bundle for serial_ripple_borrow_subtractor.
// The slave side is the subtractor, and the master side is the operand producer / result consumer.
interface serial_ripple_borrow_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_ripple_borrow_subtractor.sv
// Computes diff = a - b - bin, resolving CHUNK bits per cycle: accept -> out_valid after WIDTH/CHUNK edges; results hold while out_ready is low.
// Define SUB_OVERFLOW_EN to make the ovf flag live; when undefined, ovf is tied to 0.
module serial_ripple_borrow_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input logic                          clk,
  input logic                          rst_n,
  serial_ripple_borrow_subtractor_if.slave io
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d;

  logic [CHUNK-1:0] a_c, b_c, p, g, d_c;
  logic [CHUNK:0]   br;
  logic             last;

  assign last = (idx_q == IDXW'(N - 1));

  // Chunk select uses constant slices so every operand bit is read directly.
  always_comb begin
    a_c = '0;
    b_c = '0;
    br  = '0;
    for (int j = 0; j < N; j++) begin
      if (idx_q == IDXW'(j)) begin
        a_c = a_q[j*CHUNK +: CHUNK];
        b_c = b_q[j*CHUNK +: CHUNK];
      end
    end
    p     = ~(a_c ^ b_c);
    g     = ~a_c & b_c;
    br[0] = br_q;
    for (int i = 0; i < CHUNK; i++) begin
      br[i+1] = g[i] | (p[i] & br[i]);
    end
    d_c = a_c ^ b_c ^ br[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          br_d    = io.bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < N; j++) begin
          if (idx_q == IDXW'(j)) begin
            diff_d[j*CHUNK +: CHUNK] = d_c;
          end
        end
        br_d = br[CHUNK];
        if (last) begin
          bout_d  = br[CHUNK];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.diff      = diff_q;
  assign io.bout      = bout_q;

`ifdef SUB_OVERFLOW_EN
  // Signed overflow is the borrow into the MSB disagreeing with the borrow out of it.
  logic msb_br_q, msb_br_d;

  always_comb begin
    msb_br_d = msb_br_q;
    if (state_q == RUN && last) begin
      msb_br_d = br[CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_br_q <= 1'b0;
    end else begin
      msb_br_q <= msb_br_d;
    end
  end

  assign io.ovf = msb_br_q ^ bout_q;
`else
  assign io.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Bench for serial_ripple_borrow_subtractor: an 8-bit/4-bit-chunk instance plus one instance at default parameters.
// Expected results come from a wide arithmetic model and are queued at accept, then popped when out_valid rises.
module tb_serial_ripple_borrow_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_ripple_borrow_subtractor_if #(.WIDTH(8))  io8 ();
  serial_ripple_borrow_subtractor_if #(.WIDTH(64)) io64 ();

  serial_ripple_borrow_subtractor #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io8)
  );

  serial_ripple_borrow_subtractor dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io64)
  );

  typedef struct packed {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q64[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bin, input int w);
    exp_t        e;
    logic [64:0] r;
    logic [63:0] mask;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r      = {1'b0, a & mask} - {1'b0, b & mask} - {64'd0, bin};
    e.diff = r[63:0] & mask;
    e.bout = r[w];
`ifdef SUB_OVERFLOW_EN
    e.ovf  = (a[w-1] ^ b[w-1]) & (e.diff[w-1] ^ a[w-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int hold, input string tag);
    exp_t e;
    int   cnt;
    @(negedge clk);
    check({tag, "/in_ready_before"}, io8.in_ready, 1);
    io8.a        = a;
    io8.b        = b;
    io8.bin      = bin;
    io8.in_valid = 1'b1;
    q8.push_back(model(a, b, bin, 8));
    @(posedge clk);
    @(negedge clk);
    io8.in_valid = 1'b0;
    io8.a        = 8'($urandom);
    io8.b        = 8'($urandom);
    io8.bin      = ~bin;
    cnt = 0;
    while (!io8.out_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "/latency"}, cnt, 2);
    for (int i = 0; i < hold; i++) begin
      io8.in_valid = i[0];
      io8.a        = 8'($urandom);
      io8.b        = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s/hold%0d_diff", tag, i), io8.diff, q8[0].diff);
      check($sformatf("%s/hold%0d_bout", tag, i), io8.bout, q8[0].bout);
      check($sformatf("%s/hold%0d_in_ready", tag, i), io8.in_ready, 0);
      check($sformatf("%s/hold%0d_out_valid", tag, i), io8.out_valid, 1);
    end
    io8.in_valid = 1'b0;
    e = q8.pop_front();
    check({tag, "/diff"}, io8.diff, e.diff);
    check({tag, "/bout"}, io8.bout, e.bout);
    check({tag, "/ovf"}, io8.ovf, e.ovf);
    io8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io8.out_ready = 1'b0;
    check({tag, "/out_valid_after"}, io8.out_valid, 0);
    check({tag, "/in_ready_after"}, io8.in_ready, 1);
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic bin, input string tag);
    exp_t e;
    int   cnt;
    @(negedge clk);
    io64.a        = a;
    io64.b        = b;
    io64.bin      = bin;
    io64.in_valid = 1'b1;
    q64.push_back(model(a, b, bin, 64));
    @(posedge clk);
    @(negedge clk);
    io64.in_valid = 1'b0;
    cnt = 0;
    while (!io64.out_valid && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check({tag, "/latency"}, cnt, 8);
    e = q64.pop_front();
    check({tag, "/diff"}, io64.diff, e.diff);
    check({tag, "/bout"}, io64.bout, e.bout);
    check({tag, "/ovf"}, io64.ovf, e.ovf);
    io64.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io64.out_ready = 1'b0;
    check({tag, "/in_ready_after"}, io64.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    io8.in_valid  = 1'b0;
    io8.out_ready = 1'b0;
    io8.a         = '0;
    io8.b         = '0;
    io8.bin       = 1'b0;
    io64.in_valid  = 1'b0;
    io64.out_ready = 1'b0;
    io64.a         = '0;
    io64.b         = '0;
    io64.bin       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/in_ready", io8.in_ready, 1);
    check("reset/out_valid", io8.out_valid, 0);
    check("reset/diff", io8.diff, 0);
    check("reset/bout", io8.bout, 0);
    check("reset/ovf", io8.ovf, 0);
    rst_n = 1'b1;

    run8(8'h10, 8'h01, 1'b0, 0, "basic");
    run8(8'h00, 8'h01, 1'b0, 0, "underflow");
    run8(8'h05, 8'h05, 1'b1, 0, "bin_equal");
    run8(8'h10, 8'h00, 1'b1, 0, "bin_ripple");
    run8(8'h80, 8'h01, 1'b0, 0, "signed_ovf");
    run8(8'h80, 8'h7F, 1'b1, 0, "ovf_bin");
    run8(8'h3C, 8'hC5, 1'b0, 5, "backpressure");

    @(negedge clk);
    io8.a        = 8'hAA;
    io8.b        = 8'h55;
    io8.bin      = 1'b0;
    io8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io8.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrun_reset/in_ready", io8.in_ready, 1);
    check("midrun_reset/out_valid", io8.out_valid, 0);
    check("midrun_reset/diff", io8.diff, 0);
    check("midrun_reset/bout", io8.bout, 0);
    check("midrun_reset/ovf", io8.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | io8.out_valid;
    end
    check("midrun_reset/no_output", seen, 0);
    run8(8'h33, 8'h11, 1'b0, 0, "after_reset");

    run64(64'h0, 64'h1, 1'b0, "w64_underflow");
    run64(64'h8000_0000_0000_0000, 64'h1, 1'b0, "w64_ovf");
    run64(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1, "w64_mixed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
